// File: rtl/i2s_rx_axis_slave.sv
// i2s_rx_axis_slave: I2S target receiver emitting left/right sample pairs as an AXI-Stream master
module i2s_rx_axis_slave #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  lrck,
  input  logic                  sdin,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  aligned,
  output logic                  overrun
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  if (DATA_WIDTH > SLOT_WIDTH || DATA_WIDTH < 2) begin : g_bad_width
    $error("DATA_WIDTH must be in 2..SLOT_WIDTH");
  end
  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;
  state_t                state_q;
  logic [1:0]            sclk_sync_q, lrck_sync_q, sdin_sync_q;
  logic                  sclk_prev_q, lrck_prev_q;
  logic [DATA_WIDTH-1:0] shift_q, left_hold_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH:0]   mem_q [4];
  logic [1:0]            wp_q, rp_q;
  logic [2:0]            cnt_q;
  logic                  aligned_q, overrun_q;
  logic                  rise, lrck_s, bnd, push_req, push_ok, pop;
  logic [CW-1:0]         pad;
  logic [DATA_WIDTH-1:0] word;
  assign rise     = sclk_sync_q[1] & ~sclk_prev_q;
  assign lrck_s   = lrck_sync_q[1];
  assign bnd      = rise && (lrck_s != lrck_prev_q);
  // left-justify a possibly short slot: missing LSBs come out as zero
  assign pad      = CW'(DATA_WIDTH) - bit_cnt_q;
  assign word     = shift_q << pad;
  assign push_req = bnd && state_q == RIGHT && !lrck_s;
  // free count is taken before any same-cycle pop, so a full FIFO always drops
  assign push_ok  = push_req && cnt_q <= 3'd2;
  assign pop      = m_axis_valid && m_axis_ready;
  assign m_axis_valid = cnt_q != 3'd0;
  assign {m_axis_last, m_axis_data} = mem_q[rp_q];
  assign aligned  = aligned_q;
  assign overrun  = overrun_q;
  // input synchronizers and sclk edge / lrck history tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      lrck_sync_q <= '0;
      sdin_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      lrck_sync_q <= {lrck_sync_q[0], lrck};
      sdin_sync_q <= {sdin_sync_q[0], sdin};
      sclk_prev_q <= sclk_sync_q[1];
      lrck_prev_q <= rise ? lrck_s : lrck_prev_q;
    end
  end
  // MSB-first capture; the boundary bit is the previous slot's LSB and is skipped
  always_ff @(posedge clk) begin
    if (reset || bnd) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (rise && bit_cnt_q < CW'(DATA_WIDTH)) begin
      shift_q   <= {shift_q[DATA_WIDTH-2:0], sdin_sync_q[1]};
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end
  // channel tracking: wait for a left slot start, then alternate left/right
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALIGN;
      aligned_q   <= 1'b0;
      left_hold_q <= '0;
    end else if (bnd) begin
      case (state_q)
        ALIGN: if (!lrck_s) begin
          state_q   <= LEFT;
          aligned_q <= 1'b1;
        end
        LEFT: if (lrck_s) begin
          state_q     <= RIGHT;
          left_hold_q <= word;
        end
        RIGHT: if (!lrck_s) state_q <= LEFT;
        default: state_q <= ALIGN;
      endcase
    end
  end
  // 4-entry pair FIFO: both words of a frame are written together or both dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wp_q]        <= {1'b0, left_hold_q};
        mem_q[wp_q + 2'd1] <= {1'b1, word};
        wp_q               <= wp_q + 2'd2;
      end
      rp_q      <= pop ? rp_q + 2'd1 : rp_q;
      cnt_q     <= cnt_q + (push_ok ? 3'd2 : 3'd0) - {2'b0, pop};
      overrun_q <= push_req && !push_ok;
    end
  end
endmodule

// File: tb/tb_i2s_rx_axis_slave.sv
// tb_i2s_rx_axis_slave: scoreboard bench driving I2S frames and checking the AXIS beats
module tb_i2s_rx_axis_slave;
  logic        clk = 0, reset = 1, sclk = 0, lrck = 0, sdin = 0;
  logic        ready_man = 1, ready_t = 0, tog = 0, ready;
  logic [23:0] data;
  logic        valid, last, aligned, overrun;
  int          total = 0, bad = 0, ovr_cnt = 0;
  logic [24:0] q[$];
  logic        held_v = 0;
  logic [24:0] held;
  assign ready = tog ? ready_t : ready_man;
  i2s_rx_axis_slave #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .lrck(lrck), .sdin(sdin),
    .m_axis_data(data), .m_axis_valid(valid), .m_axis_ready(ready),
    .m_axis_last(last), .aligned(aligned), .overrun(overrun)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 ready_t = ~ready_t;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // monitor: pops expected beats on handshakes and checks stability while stalled
  always @(negedge clk) begin
    if (reset) held_v = 0;
    else begin
      if (overrun) ovr_cnt++;
      if (held_v) begin
        check("stall_valid", 32'(valid), 32'd1);
        check("stall_beat", 32'({last, data}), 32'(held));
      end
      if (valid && ready) begin
        if (q.size() == 0) check("extra_beat", 32'({last, data}), 32'hFFFF_FFFF);
        else check("beat", 32'({last, data}), 32'(q.pop_front()));
      end
      held_v = valid && !ready;
      held   = {last, data};
    end
  end
  // one I2S slot section: period 0 carries the previous LSB, then nb data bits MSB first
  task automatic send_bits(input logic c, input int p0, input int p1, input logic [23:0] w, input int nb);
    for (int p = p0; p <= p1; p++) begin
      lrck = c;
      if (p >= 1) sdin = (p <= nb) ? w[24-p] : 1'b0;
      #40 sclk = 1;
      #40 sclk = 0;
    end
  endtask
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input bit exp);
    if (exp) begin
      q.push_back({1'b0, l});
      q.push_back({1'b1, r});
    end
    send_bits(0, 0, 31, l, 24);
    send_bits(1, 0, 31, r, 24);
  endtask
  task automatic pre();
    send_bits(1, 12, 31, 24'h5A5A5A, 24);
  endtask
  task automatic tail();
    send_bits(0, 0, 3, 24'h0, 24);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
    check(tag, 32'(q.size()), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 0;
    ovr_cnt = 0;
  endtask
  initial begin
    // basic stereo stream
    do_reset();
    pre();
    frame(24'h123456, 24'hABCDEF, 1);
    frame(24'h123456, 24'hABCDEF, 1);
    tail();
    drain("t1_drain");
    check("t1_aligned", 32'(aligned), 32'd1);
    check("t1_ovr", 32'(ovr_cnt), 32'd0);
    // start in the middle of a right slot
    do_reset();
    send_bits(1, 20, 31, 24'hFFFFFF, 24);
    check("t2_not_aligned", 32'(aligned), 32'd0);
    frame(24'h111111, 24'h222222, 1);
    frame(24'h333333, 24'h444444, 1);
    tail();
    drain("t2_drain");
    // back-pressure: two frames fit, two are dropped
    do_reset();
    ready_man = 0;
    pre();
    for (int i = 0; i < 4; i++) frame(24'h100000 + 24'(i), 24'h200000 + 24'(i), i < 2);
    tail();
    repeat (10) @(negedge clk);
    check("t3_ovr", 32'(ovr_cnt), 32'd2);
    check("t3_valid", 32'(valid), 32'd1);
    ready_man = 1;
    drain("t3_drain");
    check("t3_ovr_end", 32'(ovr_cnt), 32'd2);
    // short 20-bit slots are left-justified
    do_reset();
    pre();
    for (int i = 0; i < 2; i++) begin
      q.push_back({1'b0, 24'hFFFFF0});
      q.push_back({1'b1, 24'hFFFFF0});
      send_bits(0, 0, 20, 24'hFFFFF0, 20);
      send_bits(1, 0, 20, 24'hFFFFF0, 20);
    end
    tail();
    drain("t4_drain");
    // reset in the middle of a left slot discards everything
    do_reset();
    ready_man = 0;
    pre();
    frame(24'hAAAAAA, 24'hBBBBBB, 0);
    send_bits(0, 0, 9, 24'hCCCCCC, 24);
    check("t5_pre_valid", 32'(valid), 32'd1);
    @(negedge clk);
    #1 reset = 1;
    @(negedge clk);
    #1 reset = 0;
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_aligned", 32'(aligned), 32'd0);
    ready_man = 1;
    send_bits(0, 10, 31, 24'hCCCCCC, 24);
    send_bits(1, 0, 31, 24'hDDDDDD, 24);
    frame(24'hEEEEEE, 24'h0F0F0F, 1);
    tail();
    drain("t5_drain");
    // ready toggling every clock
    do_reset();
    tog = 1;
    pre();
    for (int i = 0; i < 6; i++) frame(24'($urandom), 24'($urandom), 1);
    tail();
    drain("t6_drain");
    check("t6_ovr", 32'(ovr_cnt), 32'd0);
    tog = 0;
    repeat (20) @(negedge clk);
    check("final_queue", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
